// File: rtl/core4_pio_arbiter.sv
// Round-robin arbiter sharing one zero-wait-state PIO slave among four Avalon-MM requesters.
// Define PIO_ARB_LOCK_EN to let a requester hold exclusive ownership through req_lock.
module core4_pio_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            req_chipselect,
    input  logic [3:0]            req_write_n,
    input  logic [3:0]            req_read_n,
    input  logic [4*ADDR_W-1:0]   req_address,
    input  logic [4*DATA_W-1:0]   req_writedata,
    input  logic [3:0]            req_lock,
    output logic [4*DATA_W-1:0]   req_readdata,
    output logic [3:0]            req_waitrequest,
    output logic [ADDR_W-1:0]     pio_address,
    output logic                  pio_chipselect,
    output logic                  pio_write_n,
    output logic [DATA_W-1:0]     pio_writedata,
    input  logic [DATA_W-1:0]     pio_readdata
);

    // state  | meaning
    // S_IDLE | arbitrate among pending requesters, latch the winner's request
    // S_XFER | PIO strobe active for one cycle, read data captured at its end
    // S_DONE | granted requester sees waitrequest low for one cycle
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] grant, last_grant, pick;
    logic       pick_valid;
    logic [3:0] pending, eligible;

    assign pending = req_chipselect & (~req_write_n | ~req_read_n);

`ifdef PIO_ARB_LOCK_EN
    logic       locked;
    logic [1:0] owner;
    logic       lock_hold;

    assign lock_hold = locked && req_lock[owner];
    assign eligible  = lock_hold ? (pending & (4'b0001 << owner)) : pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked <= 1'b0;
            owner  <= 2'd0;
        end else if (state == S_DONE && req_lock[grant]) begin
            locked <= 1'b1;
            owner  <= grant;
        end else if (state == S_IDLE && locked && !req_lock[owner]) begin
            locked <= 1'b0;
        end
    end
`else
    logic lock_unused;

    assign lock_unused = ^req_lock;
    assign eligible    = pending;
`endif

    // Lowest priority is scanned first so the requester right after last_grant wins.
    always_comb begin
        pick       = last_grant;
        pick_valid = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (eligible[last_grant + 2'(k)]) begin
                pick       = last_grant + 2'(k);
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_valid) state_nxt = S_XFER;
            S_XFER:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_waitrequest = 4'hF;
        if (state == S_DONE) begin
            req_waitrequest[grant] = 1'b0;
        end
    end

    // Request fields are latched straight into the pio_* registers; pio_write_n doubles as the write flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant          <= 2'd0;
            last_grant     <= 2'd3;
            pio_address    <= '0;
            pio_writedata  <= '0;
            pio_write_n    <= 1'b1;
            pio_chipselect <= 1'b0;
            req_readdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant          <= pick;
                        last_grant     <= pick;
                        pio_address    <= req_address[pick*ADDR_W +: ADDR_W];
                        pio_writedata  <= req_writedata[pick*DATA_W +: DATA_W];
                        pio_write_n    <= req_write_n[pick];
                        pio_chipselect <= 1'b1;
                    end
                end
                S_XFER: begin
                    pio_chipselect <= 1'b0;
                    pio_write_n    <= 1'b1;
                    req_readdata[grant*DATA_W +: DATA_W] <= pio_readdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core4_pio_arbiter.sv
// Self-checking bench for core4_pio_arbiter: vector table of single accesses plus
// hand-written contention, reset-abort and lock sequences against a small PIO model.
module tb_core4_pio_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [3:0]          req_chipselect;
    logic [3:0]          req_write_n;
    logic [3:0]          req_read_n;
    logic [4*ADDR_W-1:0] req_address;
    logic [4*DATA_W-1:0] req_writedata;
    logic [3:0]          req_lock;
    logic [4*DATA_W-1:0] req_readdata;
    logic [3:0]          req_waitrequest;
    logic [ADDR_W-1:0]   pio_address;
    logic                pio_chipselect;
    logic                pio_write_n;
    logic [DATA_W-1:0]   pio_writedata;
    logic [DATA_W-1:0]   pio_readdata;

    core4_pio_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_chipselect  (req_chipselect),
        .req_write_n     (req_write_n),
        .req_read_n      (req_read_n),
        .req_address     (req_address),
        .req_writedata   (req_writedata),
        .req_lock        (req_lock),
        .req_readdata    (req_readdata),
        .req_waitrequest (req_waitrequest),
        .pio_address     (pio_address),
        .pio_chipselect  (pio_chipselect),
        .pio_write_n     (pio_write_n),
        .pio_writedata   (pio_writedata),
        .pio_readdata    (pio_readdata)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] pio_mem [4];
    logic [DATA_W-1:0] wlog_data [$];
    int                wlog_cyc [$];
    int                cyc = 0;
    int                n_tests = 0;
    int                n_fail = 0;
    logic [DATA_W-1:0] exp_rd [4];

    assign pio_readdata = pio_mem[pio_address];

    // PIO register file: a write lands at the edge closing the strobe cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && pio_chipselect && !pio_write_n) begin
            pio_mem[pio_address] <= pio_writedata;
            wlog_data.push_back(pio_writedata);
            wlog_cyc.push_back(cyc);
        end
    end

    typedef struct {
        int                req;
        logic              wr;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              exp_write_n;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        req_chipselect = 4'h0;
        req_write_n    = 4'hF;
        req_read_n     = 4'hF;
        req_lock       = 4'h0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_bus();
        for (int i = 0; i < 4; i++) exp_rd[i] = '0;
        step();
        step();
        reset_n = 1'b1;
        step();
        wlog_data.delete();
        wlog_cyc.delete();
    endtask

    task automatic put_req(input int r, input logic wr, input logic rd,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_chipselect[r] = 1'b1;
        req_write_n[r]    = ~wr;
        req_read_n[r]     = ~rd;
        req_address[r*ADDR_W +: ADDR_W] = a;
        req_writedata[r*DATA_W +: DATA_W] = d;
    endtask

    function automatic logic [4*DATA_W-1:0] packed_rd();
        logic [4*DATA_W-1:0] p;
        for (int i = 0; i < 4; i++) p[i*DATA_W +: DATA_W] = exp_rd[i];
        return p;
    endfunction

    // Each requester withdraws once it sees its waitrequest low.
    task automatic serve_all(input string name, input int budget);
        int n;
        n = 0;
        while (req_chipselect != 4'h0 && n < budget) begin
            step();
            n++;
            for (int i = 0; i < 4; i++) begin
                if (req_chipselect[i] && !req_waitrequest[i]) begin
                    req_chipselect[i] = 1'b0;
                    req_write_n[i]    = 1'b1;
                    req_read_n[i]     = 1'b1;
                end
            end
        end
        if (req_chipselect != 4'h0) check({name, "_timeout"}, 0, 1);
        step();
    endtask

    initial begin
        logic [3:0]        expw;
        logic [DATA_W-1:0] exp_lock [3];
        int                n0, n, wr_low;

        pio_mem[0] = 32'h0000005A;
        pio_mem[1] = 32'h0000000F;
        pio_mem[2] = 32'h000000F0;
        pio_mem[3] = 32'h0000003C;
        req_address   = '0;
        req_writedata = '0;
        idle_bus();

        vecs[0] = '{1, 1'b0, 1'b1, 2'd0, 32'h00, 1'b1, 32'h5A};
        vecs[1] = '{2, 1'b1, 1'b0, 2'd0, 32'hA5, 1'b0, 32'h5A};
        vecs[2] = '{0, 1'b0, 1'b1, 2'd0, 32'h00, 1'b1, 32'hA5};
        vecs[3] = '{3, 1'b1, 1'b0, 2'd3, 32'h77, 1'b0, 32'h3C};
        vecs[4] = '{3, 1'b0, 1'b1, 2'd3, 32'h00, 1'b1, 32'h77};
        vecs[5] = '{1, 1'b1, 1'b1, 2'd1, 32'h99, 1'b0, 32'h0F};
        vecs[6] = '{2, 1'b0, 1'b1, 2'd1, 32'h00, 1'b1, 32'h99};

        // Reset state
        step();
        check("rst_waitreq", req_waitrequest, 4'hF);
        check("rst_cs", pio_chipselect, 1'b0);
        check("rst_write_n", pio_write_n, 1'b1);
        check("rst_readdata", req_readdata, '0);
        check("rst_addr", pio_address, '0);
        check("rst_wdata", pio_writedata, '0);
        reset_n = 1'b1;
        step();

        // Single accesses from the table
        for (int v = 0; v < 7; v++) begin
            put_req(vecs[v].req, vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].wdata);
            step();
            check("xfer_cs", pio_chipselect, 1'b1);
            check("xfer_write_n", pio_write_n, vecs[v].exp_write_n);
            check("xfer_addr", pio_address, vecs[v].addr);
            check("xfer_wdata", pio_writedata, vecs[v].wdata);
            check("xfer_waitreq", req_waitrequest, 4'hF);
            step();
            expw = 4'hF;
            expw[vecs[v].req] = 1'b0;
            exp_rd[vecs[v].req] = vecs[v].exp_rdata;
            check("done_waitreq", req_waitrequest, expw);
            check("done_readdata", req_readdata, packed_rd());
            check("done_cs", pio_chipselect, 1'b0);
            idle_bus();
            step();
            check("idle_waitreq", req_waitrequest, 4'hF);
        end

        // Contention: all four from the same cycle, then 0 and 1 again
        do_reset();
        for (int i = 0; i < 4; i++) put_req(i, 1'b1, 1'b0, 2'(i), 32'h11 * (i + 1));
        serve_all("cont", 40);
        check("cont_count", wlog_data.size(), 4);
        check("cont_w0", wlog_data[0], 32'h11);
        check("cont_w1", wlog_data[1], 32'h22);
        check("cont_w2", wlog_data[2], 32'h33);
        check("cont_w3", wlog_data[3], 32'h44);
        for (int i = 0; i < 3; i++) check("cont_spacing", wlog_cyc[i+1] - wlog_cyc[i], 3);
        wlog_data.delete();
        wlog_cyc.delete();
        put_req(0, 1'b1, 1'b0, 2'd0, 32'h55);
        put_req(1, 1'b1, 1'b0, 2'd1, 32'h66);
        serve_all("round2", 20);
        check("round2_count", wlog_data.size(), 2);
        check("round2_w0", wlog_data[0], 32'h55);
        check("round2_w1", wlog_data[1], 32'h66);

        // Reset during the strobe cycle aborts the access
        do_reset();
        put_req(3, 1'b1, 1'b0, 2'd2, 32'hEE);
        step();
        check("abort_granted", pio_chipselect, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_cs", pio_chipselect, 1'b0);
        check("abort_write_n", pio_write_n, 1'b1);
        check("abort_waitreq", req_waitrequest, 4'hF);
        idle_bus();
        step();
        step();
        reset_n = 1'b1;
        wr_low = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (req_waitrequest != 4'hF) wr_low++;
        end
        check("abort_no_ack", wr_low, 0);
        check("abort_no_write", wlog_data.size(), 0);
        check("abort_mem", pio_mem[2], 32'h33);

        // Lock sequence: requester 0 locks while requester 1 is pending
`ifdef PIO_ARB_LOCK_EN
        exp_lock[0] = 32'hA0; exp_lock[1] = 32'hA1; exp_lock[2] = 32'hB1;
`else
        exp_lock[0] = 32'hA0; exp_lock[1] = 32'hB1; exp_lock[2] = 32'hA1;
`endif
        do_reset();
        put_req(0, 1'b1, 1'b0, 2'd0, 32'hA0);
        req_lock[0] = 1'b1;
        put_req(1, 1'b1, 1'b0, 2'd1, 32'hB1);
        n0 = 0;
        n = 0;
        while (req_chipselect != 4'h0 && n < 40) begin
            step();
            n++;
            if (req_chipselect[0] && !req_waitrequest[0]) begin
                n0++;
                if (n0 == 1) begin
                    req_writedata[DATA_W-1:0] = 32'hA1;
                end else begin
                    req_chipselect[0] = 1'b0;
                    req_write_n[0]    = 1'b1;
                    req_lock[0]       = 1'b0;
                end
            end
            if (req_chipselect[1] && !req_waitrequest[1]) begin
                req_chipselect[1] = 1'b0;
                req_write_n[1]    = 1'b1;
            end
        end
        if (req_chipselect != 4'h0) check("lock_timeout", 0, 1);
        step();
        check("lock_count", wlog_data.size(), 3);
        for (int i = 0; i < 3; i++) check("lock_order", wlog_data[i], exp_lock[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
